// File: rtl/aes_key_expander_pkg.sv
// Shared types, constants and helpers for the AES key-schedule engine.
// Optional feature macro: AES_KEY_EXP_INV_EN (InvMixColumns helpers live here unconditionally).
package aes_key_expander_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    KEY128 = 2'd0,
    KEY192 = 2'd1,
    KEY256 = 2'd2
  } keyMode_t;

  typedef enum logic [1:0] {
    KX_IDLE  = 2'd0,
    KX_GEN   = 2'd1,
    KX_DRAIN = 2'd2
  } kx_state_t;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  function automatic logic [3:0] nk_of(input keyMode_t m);
    case (m)
      KEY128:  return 4'd4;
      KEY192:  return 4'd6;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input keyMode_t m);
    case (m)
      KEY128:  return 4'd10;
      KEY192:  return 4'd12;
      default: return 4'd14;
    endcase
  endfunction

  // Out-of-range index (only reachable while key words are still loading) yields 0
  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    if (r >= 4'd1 && r <= 4'd10) return RCON[r];
    return 8'h00;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul9(input logic [7:0] b);
    return xt(xt(xt(b))) ^ b;
  endfunction

  function automatic logic [7:0] gmul11(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(b) ^ b;
  endfunction

  function automatic logic [7:0] gmul13(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
  endfunction

  function automatic logic [7:0] gmul14(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
  endfunction

  function automatic word_t inv_mix_col(input word_t c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3),
            gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3),
            gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3),
            gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3)};
  endfunction

  function automatic logic [127:0] inv_mix_cols(input logic [127:0] k);
    logic [127:0] r;
    for (int g = 0; g < 4; g++) r[32*g +: 32] = inv_mix_col(k[32*g +: 32]);
    return r;
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box lanes on one schedule word.
module aes_sub_word
  import aes_key_expander_pkg::*;
#(
  parameter int NUM_LANES = 4
) (
  input  word_t din,
  output word_t dout
);

  logic [NUM_LANES-1:0][7:0] din_b, dout_b;

  assign din_b = din;
  assign dout  = dout_b;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign dout_b[g] = SBOX[din_b[g]];
  end

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES key schedule: one word per cycle, round keys streamed over valid/ready.
// Optional feature macro: AES_KEY_EXP_INV_EN adds keyInverse (equivalent-inverse schedule).
module aes_key_expander
  import aes_key_expander_pkg::*;
#(
  parameter int MAX_KEY_BITS = 256,
  parameter int MAX_NK       = MAX_KEY_BITS / 32
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    keyValid,
  output logic                    keyReady,
  input  logic [1:0]              keyMode,
  input  logic [MAX_KEY_BITS-1:0] keyIn,
`ifdef AES_KEY_EXP_INV_EN
  input  logic                    keyInverse,
`endif
  output logic                    keyError,
  output logic                    rkValid,
  input  logic                    rkReady,
  output logic [3:0]              rkIndex,
  output logic [127:0]            roundKey,
  output logic                    rkLast
);

  localparam int IW = $clog2(MAX_NK);

  kx_state_t st, st_nxt;

  logic [3:0]              nk_r, nr_r, r_r;
  logic [5:0]              i_r;
  logic [2:0]              m_r;
  logic [MAX_KEY_BITS-1:0] key_r;
  word_t                   win [MAX_NK];
  logic                    err_r;
`ifdef AES_KEY_EXP_INV_EN
  logic                    inv_r;
`endif

  logic         out_vld, buf_vld;
  logic [3:0]   out_idx, buf_idx;
  logic [127:0] out_key, buf_key;

  logic         accept, mode_ok, stall, prod, last_word, grp_done, out_free;
  logic [IW-1:0] nk_m1;
  logic [5:0]   w_tot;
  word_t        w_prev, sub_in, sub_out, temp, w_new;
  logic [3:0]   grp_idx;
  logic [127:0] grp_raw, grp_key;

  assign accept  = (st == KX_IDLE) && keyValid;
  assign mode_ok = (keyMode != 2'd3) &&
                   (32 * int'(nk_of(keyMode_t'(keyMode))) <= MAX_KEY_BITS);

  // Stall only when the output is blocked and the spare group slot is occupied
  assign stall     = out_vld && !rkReady && buf_vld;
  assign prod      = (st == KX_GEN) && !stall;
  assign nk_m1     = IW'(nk_r - 4'd1);
  assign w_tot     = ({2'b00, nr_r} + 6'd1) << 2;
  assign last_word = (i_r == w_tot - 6'd1);

  // One S-box block serves both the rotated (i mod Nk == 0) and plain paths
  assign w_prev = win[0];
  assign sub_in = (m_r == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  aes_sub_word u_sub (
    .din  (sub_in),
    .dout (sub_out)
  );

  // Next schedule word: key words first, then the recurrence
  always_comb begin
    temp = w_prev;
    if (m_r == 3'd0)                           temp = sub_out ^ {rcon_of(r_r), 24'h0};
    else if (nk_r == 4'd8 && m_r == 3'd4)      temp = sub_out;
    w_new = (r_r == 4'd0) ? key_r[MAX_KEY_BITS-1 -: 32] : (win[nk_m1] ^ temp);
  end

  // A group closes on every fourth word; the three older words sit in the window
  assign grp_done = prod && (i_r[1:0] == 2'b11);
  assign grp_idx  = i_r[5:2];
  assign grp_raw  = {win[2], win[1], win[0], w_new};
`ifdef AES_KEY_EXP_INV_EN
  assign grp_key  = (inv_r && grp_idx != 4'd0 && grp_idx != nr_r) ? inv_mix_cols(grp_raw) : grp_raw;
`else
  assign grp_key  = grp_raw;
`endif

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) st <= KX_IDLE;
    else          st <= st_nxt;
  end

  // FSM next state
  always_comb begin
    st_nxt = st;
    case (st)
      KX_IDLE:  if (accept && mode_ok)               st_nxt = KX_GEN;
      KX_GEN:   if (prod && last_word)               st_nxt = KX_DRAIN;
      KX_DRAIN: if (out_vld && rkReady && !buf_vld)  st_nxt = KX_IDLE;
      default:                                       st_nxt = KX_IDLE;
    endcase
  end

  // Request capture, word counters and the sliding word window
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      nk_r  <= '0;
      nr_r  <= '0;
      r_r   <= '0;
      i_r   <= '0;
      m_r   <= '0;
      key_r <= '0;
      err_r <= 1'b0;
`ifdef AES_KEY_EXP_INV_EN
      inv_r <= 1'b0;
`endif
      for (int k = 0; k < MAX_NK; k++) win[k] <= '0;
    end else begin
      err_r <= accept && !mode_ok;
      if (accept && mode_ok) begin
        nk_r  <= nk_of(keyMode_t'(keyMode));
        nr_r  <= nr_of(keyMode_t'(keyMode));
        key_r <= keyIn;
        i_r   <= '0;
        m_r   <= '0;
        r_r   <= '0;
`ifdef AES_KEY_EXP_INV_EN
        inv_r <= keyInverse;
`endif
      end else if (prod) begin
        i_r   <= i_r + 6'd1;
        key_r <= key_r << 32;
        if ({1'b0, m_r} == nk_r - 4'd1) begin
          m_r <= '0;
          r_r <= r_r + 4'd1;
        end else begin
          m_r <= m_r + 3'd1;
        end
        win[0] <= w_new;
        for (int k = 1; k < MAX_NK; k++) win[k] <= win[k-1];
      end
    end
  end

  assign out_free = !out_vld || rkReady;

  // Output register plus one spare group; spare drains into output on accept
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_vld <= 1'b0;
      out_idx <= '0;
      out_key <= '0;
      buf_vld <= 1'b0;
      buf_idx <= '0;
      buf_key <= '0;
    end else if (out_free) begin
      if (buf_vld) begin
        out_vld <= 1'b1;
        out_idx <= buf_idx;
        out_key <= buf_key;
        buf_vld <= grp_done;
        if (grp_done) begin
          buf_idx <= grp_idx;
          buf_key <= grp_key;
        end
      end else begin
        out_vld <= grp_done;
        if (grp_done) begin
          out_idx <= grp_idx;
          out_key <= grp_key;
        end
      end
    end else if (grp_done) begin
      buf_vld <= 1'b1;
      buf_idx <= grp_idx;
      buf_key <= grp_key;
    end
  end

  assign keyReady = (st == KX_IDLE);
  assign keyError = err_r;
  assign rkValid  = out_vld;
  assign rkIndex  = out_idx;
  assign roundKey = out_key;
  assign rkLast   = out_vld && (out_idx == nr_r);

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander using the FIPS-197 appendix A key schedules.
module tb_aes_key_expander;

  logic         clock, reset_n, keyValid, keyReady, keyError, rkValid, rkReady, rkLast;
  logic [1:0]   keyMode;
  logic [255:0] keyIn;
  logic [3:0]   rkIndex;
  logic [127:0] roundKey;
`ifdef AES_KEY_EXP_INV_EN
  logic         keyInverse;
`endif

  int n_chk = 0;
  int n_err = 0;

  logic [127:0] a1_tab [0:10];
  logic [127:0] exp_tab [0:14];
  bit           known [0:14];

  aes_key_expander #(.MAX_KEY_BITS(256)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .keyValid (keyValid),
    .keyReady (keyReady),
    .keyMode  (keyMode),
    .keyIn    (keyIn),
`ifdef AES_KEY_EXP_INV_EN
    .keyInverse(keyInverse),
`endif
    .keyError (keyError),
    .rkValid  (rkValid),
    .rkReady  (rkReady),
    .rkIndex  (rkIndex),
    .roundKey (roundKey),
    .rkLast   (rkLast)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Bench-side GF(2^8) multiply by shift-and-add
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] tb_inv_mix(input logic [127:0] k);
    logic [127:0] r;
    logic [7:0] a [4];
    for (int c = 0; c < 4; c++) begin
      for (int b = 0; b < 4; b++) a[b] = k[127 - 32*c - 8*b -: 8];
      for (int b = 0; b < 4; b++)
        r[127 - 32*c - 8*b -: 8] = gf_mul(a[b], 8'h0e) ^ gf_mul(a[(b+1)%4], 8'h0b) ^
                                   gf_mul(a[(b+2)%4], 8'h0d) ^ gf_mul(a[(b+3)%4], 8'h09);
    end
    return r;
  endfunction

  task automatic clear_known();
    for (int k = 0; k < 15; k++) begin
      known[k]   = 1'b0;
      exp_tab[k] = '0;
    end
  endtask

  // Issue one request and consume its round keys; stop_after >= 0 returns early after that index
  task automatic run_key(input logic [1:0] mode, input logic [255:0] key, input logic inv,
                         input bit rnd, input int nr, input int stop_after);
    logic [127:0] pk;
    logic [3:0]   pi;
    bit           pstall, rdy, done;
    int           cyc, exp_idx, first_last;
    @(negedge clock);
    keyValid = 1'b1;
    keyMode  = mode;
    keyIn    = key;
`ifdef AES_KEY_EXP_INV_EN
    keyInverse = inv;
`else
    if (inv) $display("note: inverse request ignored in this build");
`endif
    @(negedge clock);
    keyValid = 1'b0;
    keyIn    = '0;
    cyc = 0; exp_idx = 0; pstall = 0; first_last = -1; done = 0;
    pk = '0; pi = '0;
    while (!done) begin
      @(negedge clock);
      cyc++;
      if (cyc == 2) chk("busy_keyReady", keyReady, 0);
      if (pstall) begin
        chk("stall_valid", rkValid, 1);
        chk("stall_key", roundKey, pk);
        chk("stall_idx", rkIndex, pi);
      end
      if (rkValid && int'(rkIndex) == nr && first_last < 0) first_last = cyc;
      rdy = rnd ? bit'($urandom_range(0, 1)) : 1'b1;
      rkReady = rdy;
      if (rkValid && rdy) begin
        chk("rk_idx", rkIndex, exp_idx);
        if (known[exp_idx]) chk($sformatf("rk_key%0d", exp_idx), roundKey, exp_tab[exp_idx]);
        chk("rk_last", rkLast, exp_idx == nr);
        if (exp_idx == nr || exp_idx == stop_after) done = 1;
        exp_idx++;
      end
      pstall = rkValid && !rdy;
      pk = roundKey;
      pi = rkIndex;
      if (cyc > 600) begin
        chk("timeout_keys", exp_idx, nr + 1);
        done = 1;
      end
    end
    rkReady = 1'b1;
    if (stop_after < 0) begin
      if (!rnd) chk("last_latency", first_last, 4 * (nr + 1));
      @(negedge clock);
      chk("end_valid", rkValid, 0);
      chk("end_keyReady", keyReady, 1);
    end
  endtask

  logic [255:0] key_a1, key_a2, key_a3;
  bit saw_vld, saw_busy;

  initial begin
    a1_tab[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    a1_tab[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    a1_tab[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    a1_tab[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    a1_tab[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    a1_tab[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    a1_tab[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    a1_tab[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    a1_tab[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    a1_tab[9]  = 128'hac7766f319fadc2128d12941575c006e;
    a1_tab[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    // Unused LSBs carry junk so that left alignment is exercised
    key_a1 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0123456789abcdeffedcba9876543210};
    key_a2 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hffffffffffffffff};
    key_a3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    reset_n = 1'b0; keyValid = 1'b0; keyMode = 2'd0; keyIn = '0; rkReady = 1'b1;
`ifdef AES_KEY_EXP_INV_EN
    keyInverse = 1'b0;
`endif
    repeat (3) @(negedge clock);
    chk("rst_keyReady", keyReady, 1);
    chk("rst_keyError", keyError, 0);
    chk("rst_rkValid", rkValid, 0);
    chk("rst_rkIndex", rkIndex, 0);
    chk("rst_roundKey", roundKey, 0);
    chk("rst_rkLast", rkLast, 0);
    reset_n = 1'b1;
    @(negedge clock);

    // 128-bit full schedule, no backpressure
    clear_known();
    for (int k = 0; k < 11; k++) begin known[k] = 1'b1; exp_tab[k] = a1_tab[k]; end
    run_key(2'd0, key_a1, 1'b0, 1'b0, 10, -1);

    // 192-bit and 256-bit final keys
    clear_known();
    known[12] = 1'b1; exp_tab[12] = 128'he98ba06f448c773c8ecc720401002202;
    run_key(2'd1, key_a2, 1'b0, 1'b0, 12, -1);
    clear_known();
    known[14] = 1'b1; exp_tab[14] = 128'hfe4890d1e6188d0b046df344706c631e;
    run_key(2'd2, key_a3, 1'b0, 1'b0, 14, -1);

    // 128-bit with random backpressure
    clear_known();
    for (int k = 0; k < 11; k++) begin known[k] = 1'b1; exp_tab[k] = a1_tab[k]; end
    run_key(2'd0, key_a1, 1'b0, 1'b1, 10, -1);

    // Reserved mode is rejected
    @(negedge clock);
    keyValid = 1'b1; keyMode = 2'd3; keyIn = key_a3;
    @(negedge clock);
    keyValid = 1'b0;
    chk("err_pulse", keyError, 1);
    chk("err_keyReady", keyReady, 1);
    @(negedge clock);
    chk("err_pulse_end", keyError, 0);
    saw_vld = 0; saw_busy = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (rkValid) saw_vld = 1;
      if (!keyReady) saw_busy = 1;
    end
    chk("err_no_rk", saw_vld, 0);
    chk("err_stays_idle", saw_busy, 0);

    // Reset mid-generation after round key 3 is consumed, then a clean rerun
    run_key(2'd0, key_a1, 1'b0, 1'b0, 10, 3);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_keyReady", keyReady, 1);
    chk("mid_rst_rkValid", rkValid, 0);
    chk("mid_rst_rkIndex", rkIndex, 0);
    chk("mid_rst_roundKey", roundKey, 0);
    chk("mid_rst_rkLast", rkLast, 0);
    chk("mid_rst_keyError", keyError, 0);
    @(negedge clock);
    reset_n = 1'b1;
    saw_vld = 0;
    repeat (3) begin
      @(negedge clock);
      if (rkValid) saw_vld = 1;
    end
    chk("post_rst_no_rk", saw_vld, 0);
    chk("post_rst_keyReady", keyReady, 1);
    run_key(2'd0, key_a1, 1'b0, 1'b0, 10, -1);

`ifdef AES_KEY_EXP_INV_EN
    // Equivalent-inverse schedule: ends unchanged, middle keys InvMixColumns'd
    clear_known();
    for (int k = 0; k < 11; k++) begin
      known[k]   = 1'b1;
      exp_tab[k] = (k == 0 || k == 10) ? a1_tab[k] : tb_inv_mix(a1_tab[k]);
    end
    run_key(2'd0, key_a1, 1'b1, 1'b0, 10, -1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
- Iterative AES key-schedule engine. Accepts one cipher key per request; key length (128/192/256) is selected at run time.
- Produces one 32-bit schedule word per cycle and streams the Nr+1 round keys out over a valid/ready interface, in order.
- Sits between the host key-load path and the round datapath. It replaces the fixed compile-time key-size selection with per-request mode selection, up to a parametrised maximum.

Parameters:
- MAX_KEY_BITS, 256, largest supported key length; legal values 128, 192, 256. Sets key-port width and window depth.
- MAX_NK, MAX_KEY_BITS/32, depth of the word window register.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- keyValid  in  1  request present.
- keyReady  out  1  engine idle and can accept a request.
- keyMode  in  2  key length: 0=128, 1=192, 2=256, 3=reserved.
- keyIn  in  MAX_KEY_BITS  cipher key, byte 0 in the MSBs. Shorter keys are left-aligned; unused LSBs are ignored.
- keyError  out  1  one-cycle pulse when a request is rejected.
- rkValid  out  1  roundKey valid.
- rkReady  in  1  consumer accepts roundKey.
- rkIndex  out  4  round number of the presented key, 0..Nr.
- roundKey  out  128  round key, state_t byte order.
- rkLast  out  1  high with rkValid when rkIndex==Nr.

Behaviour:
- Reset values (asynchronous, on reset_n low):
  - outputs: keyReady=1, keyError=0, rkValid=0, rkIndex=0, roundKey=0, rkLast=0.
  - state: FSM=IDLE; word counter, window and group buffer cleared.
- Request acceptance: a request is accepted on a cycle with keyValid && keyReady. keyMode and keyIn are sampled in that cycle only.
- Illegal modes: keyMode=3, or a mode above MAX_KEY_BITS, is rejected. keyError pulses the next cycle, FSM stays IDLE, and no round key is produced.
- Mode constants: Nk=4/6/8 and Nr=10/12/14 for 128/192/256. Total words W=4(Nr+1) = 44/52/60.
- FSM states:
  - IDLE: keyReady=1. A legal accept goes to GEN with i=0.
  - GEN: one word w[i] per cycle, while not stalled.
    - For i<Nk, w[i] is taken from the key.
    - Otherwise w[i] = w[i-Nk] ^ temp.
    - temp = SubWord(RotWord(w[i-1])) ^ Rcon[i/Nk] when i mod Nk==0.
    - temp = SubWord(w[i-1]) when Nk==8 and i mod Nk==4.
    - otherwise temp = w[i-1].
    - Rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
    - After w[W-1] is produced, go to DRAIN.
  - DRAIN: wait until the final round key is accepted, then go to IDLE.
- Word window: a shift register holding the last Nk words. Nk is selected by mode; only the first Nk entries are used.
- Round-key emission:
  - Every 4 words form a group. Group j completes when w[4j+3] is written.
  - Group j loads the output register the cycle after it completes. rkValid rises with rkIndex=j.
  - Unstalled latency: rkValid for key j is first high 4(j+1) cycles after the accept cycle. The final key appears W cycles after accept.
- Backpressure:
  - While rkValid && !rkReady, the output register holds steady and generation continues into a one-group buffer.
  - Generation stalls (i frozen) when that buffer is full and the output has not been accepted.
  - On acceptance, the buffered group moves to the output in the same cycle, so there are no bubbles.
- Simultaneous events:
  - rkReady together with the loading of the final key: rkValid drops the following cycle and the FSM goes to IDLE.
  - keyReady is low throughout GEN/DRAIN. keyValid during busy is ignored and must be held by the source.
- Reset mid-operation: all progress is discarded immediately and no partial key is presented after release.

Optional Feature:
- Macro: AES_KEY_EXP_INV_EN.
- With the macro defined:
  - Adds input keyInverse (1 bit), sampled at accept.
  - When keyInverse=1, round keys 1..Nr-1 have InvMixColumns applied per column before loading to output. This uses the GF multiply-by-9/11/13/14 functions and yields the equivalent-inverse-cipher schedule.
  - Keys 0 and Nr pass through unchanged.
  - Emission order is unchanged and latency is +0 cycles (the transform is combinational on the load path).
- Without the macro: no port is added and round keys are always the forward schedule.

Decomposition:
- Shared package additions:
  - keyMode_t enum (KEY128, KEY192, KEY256).
  - word_t (logic [31:0]).
  - Rcon constant array [1:10].
  - Nk/Nr lookup functions indexed by keyMode_t.
- Sub-module aes_sub_word: combinational, 4 parallel S-box lookups on one word_t. It is instantiated once, shared between the RotWord and non-rotated paths via a mux.

Test Plan:
- 128-bit FIPS-197 A.1 key 2b7e1516_28aed2a6_abf71588_09cf4f3c, rkReady=1 → 11 keys; rkIndex=10 is d014f9a8_c9ee2589_e13f0cc8_b6630ca6 with rkLast=1, 44 cycles after accept.
- 192-bit A.2 key 8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b → rkIndex=12 is e98ba06f_448c773c_8ecc7204_01002202.
- 256-bit A.3 key 603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4 → rkIndex=14 is fe4890d1_e6188d0b_046df344_706c631e.
- A.1 key with rkReady randomly low 50% → identical key sequence, no duplicates or drops, roundKey stable while stalled.
- keyMode=3 → keyError one-cycle pulse, rkValid never asserts, keyReady stays 1. Also: reset_n low mid-GEN (after rkIndex=3) → all outputs return to reset values; a new A.1 request completes correctly.
- AES_KEY_EXP_INV_EN, A.1 key, keyInverse=1 → rkIndex=0 is 2b7e1516_28aed2a6_abf71588_09cf4f3c and rkIndex=10 is d014f9a8_c9ee2589_e13f0cc8_b6630ca6 (both unchanged); rkIndex=1..9 equal InvMixColumns of the forward keys.
